// File: rtl/rx_word_loader_pkg.sv
// Shared definitions for the rx word loader: state encoding, default widths and
// the terminator word that closes a load session.
package rx_word_loader_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_WORD_WIDTH = 32;
    localparam int BYTES_PER_WORD = DEF_WORD_WIDTH / DEF_DATA_WIDTH;
    localparam logic [DEF_WORD_WIDTH-1:0] DEF_HALT_WORD = 32'hFFFF_FFFF;

    // One-hot loader states
    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_RECV  = 5'b00010,
        S_WRITE = 5'b00100,
        S_DONE  = 5'b01000,
        S_ERROR = 5'b10000
    } state_t;

    // Width of a byte index able to count 0 .. bytesPerWord-1
    function automatic int idxWidth(input int bytesPerWord);
        return (bytesPerWord > 1) ? $clog2(bytesPerWord) : 1;
    endfunction

endpackage

// File: rtl/rx_word_loader_if.sv
// Byte stream from the UART receiver and the instruction-memory write port,
// bundled so the loader and its environment see one connection.
interface rx_word_loader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);

    logic                  rx_done;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WORD_WIDTH-1:0] mem_data;

    // Environment side: supplies bytes, observes memory writes
    modport master (
        output rx_done,
        output rx_data,
        input  mem_we,
        input  mem_addr,
        input  mem_data
    );

    // Loader side: consumes bytes, drives memory writes
    modport slave (
        input  rx_done,
        input  rx_data,
        output mem_we,
        output mem_addr,
        output mem_data
    );

endinterface

// File: rtl/rx_word_loader_byte_packer.sv
// Turns the level-style rx done flag into one strobe per byte and packs bytes
// MSB-first into a word. Only the leading bytes are stored; the final byte is
// taken straight from the input when the word completes.
module rx_word_loader_byte_packer
    import rx_word_loader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int WORD_WIDTH = DEF_WORD_WIDTH
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_rx_done,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic                  i_enable,
    input  logic                  i_clear,
    output logic                  o_byteStrobe,
    output logic                  o_partial,
    output logic                  o_wordReady,
    output logic [WORD_WIDTH-1:0] o_word
);

    localparam int BPW = WORD_WIDTH / DATA_WIDTH;
    localparam int IW  = idxWidth(BPW);
    localparam int PW  = WORD_WIDTH - DATA_WIDTH;

    logic          r_rxDoneQ;
    logic [IW-1:0] r_byteIdx;
    logic [PW-1:0] r_partial;
    logic          w_byteStrobe;
    logic          w_lastByte;

    assign w_byteStrobe = i_rx_done & ~r_rxDoneQ;
    assign w_lastByte   = (r_byteIdx == IW'(BPW - 1));

    assign o_byteStrobe = w_byteStrobe;
    assign o_partial    = (r_byteIdx != '0);
    assign o_wordReady  = i_enable & w_byteStrobe & w_lastByte;
    assign o_word       = {r_partial, i_rx_data};

    // Delay the done level by one cycle in every state so a held byte counts once
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_rxDoneQ <= 1'b0;
        end else begin
            r_rxDoneQ <= i_rx_done;
        end
    end

    // Shift accepted bytes in and advance the byte index, wrapping on word completion
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_byteIdx <= '0;
            r_partial <= '0;
        end else if (i_clear) begin
            r_byteIdx <= '0;
            r_partial <= '0;
        end else if (i_enable && w_byteStrobe) begin
            r_partial <= PW'({r_partial, i_rx_data});
            r_byteIdx <= w_lastByte ? '0 : r_byteIdx + IW'(1);
        end
    end

endmodule

// File: rtl/rx_word_loader.sv
// Loads instruction memory from the UART byte stream: packs bytes into words,
// writes them at incrementing addresses, and stops on the halt word, on an
// inter-byte timeout, or when memory is full.
module rx_word_loader
    import rx_word_loader_pkg::*;
#(
    parameter int                    DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int                    WORD_WIDTH     = DEF_WORD_WIDTH,
    parameter int                    ADDR_WIDTH     = 10,
    parameter logic [WORD_WIDTH-1:0] HALT_WORD      = DEF_HALT_WORD,
    parameter int                    TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    rx_word_loader_if.slave       bus,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_load_done,
    output logic                  o_load_error,
    output logic [ADDR_WIDTH:0]   o_word_count
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [WORD_WIDTH-1:0] r_memData;
    logic                  r_memWe;
    logic                  r_busy;
    logic                  r_loadDone;
    logic                  r_loadError;
    logic [TW-1:0]         r_timer;

    logic                  w_enable;
    logic                  w_clear;
    logic                  w_byteStrobe;
    logic                  w_partial;
    logic                  w_wordReady;
    logic [WORD_WIDTH-1:0] w_word;
    logic                  w_timedOut;

    assign w_enable   = (r_state == S_RECV) || (r_state == S_WRITE);
    assign w_clear    = i_start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));
    assign w_timedOut = !w_byteStrobe && w_partial && (r_timer == TW'(TIMEOUT_CYCLES - 1));

    rx_word_loader_byte_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_packer (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_rx_done    (bus.rx_done),
        .i_rx_data    (bus.rx_data),
        .i_enable     (w_enable),
        .i_clear      (w_clear),
        .o_byteStrobe (w_byteStrobe),
        .o_partial    (w_partial),
        .o_wordReady  (w_wordReady),
        .o_word       (w_word)
    );

    assign bus.mem_we   = r_memWe;
    assign bus.mem_addr = r_addr;
    assign bus.mem_data = r_memData;
    assign o_busy       = r_busy;
    assign o_load_done  = r_loadDone;
    assign o_load_error = r_loadError;
    assign o_word_count = r_count;

    // Session FSM with registered status flags, address/count tracking and the inter-byte timeout
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_count     <= '0;
            r_memData   <= '0;
            r_memWe     <= 1'b0;
            r_busy      <= 1'b0;
            r_loadDone  <= 1'b0;
            r_loadError <= 1'b0;
            r_timer     <= '0;
        end else begin
            r_memWe <= 1'b0;
            unique case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (i_start) begin
                        r_state     <= S_RECV;
                        r_addr      <= '0;
                        r_count     <= '0;
                        r_timer     <= '0;
                        r_busy      <= 1'b1;
                        r_loadDone  <= 1'b0;
                        r_loadError <= 1'b0;
                    end
                end
                S_RECV: begin
                    if (w_byteStrobe) begin
                        r_timer <= '0;
                    end else if (w_partial) begin
                        r_timer <= r_timer + TW'(1);
                    end
                    if (w_wordReady) begin
                        if (w_word == HALT_WORD) begin
                            r_state    <= S_DONE;
                            r_busy     <= 1'b0;
                            r_loadDone <= 1'b1;
                        end else if (r_count == FULL_COUNT) begin
                            r_state     <= S_ERROR;
                            r_busy      <= 1'b0;
                            r_loadError <= 1'b1;
                        end else begin
                            r_state   <= S_WRITE;
                            r_memWe   <= 1'b1;
                            r_memData <= w_word;
                        end
                    end else if (w_timedOut) begin
                        r_state     <= S_ERROR;
                        r_busy      <= 1'b0;
                        r_loadError <= 1'b1;
                    end
                end
                S_WRITE: begin
                    r_state <= S_RECV;
                    r_addr  <= r_addr + ADDR_WIDTH'(1);
                    r_count <= r_count + (ADDR_WIDTH + 1)'(1);
                    if (w_byteStrobe) begin
                        r_timer <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_word_loader.sv
// Bench for rx_word_loader: directed sessions with literal expectations plus a
// randomized byte/start/reset stream checked every cycle against a queue-based
// model of the loader.
module tb_rx_word_loader;

    localparam int AW  = 2;
    localparam int TO  = 100;
    localparam int CAP = 1 << AW;

    typedef enum int {M_IDLE, M_ACTIVE, M_DONE, M_ERROR} mphase_t;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    logic          clock;
    logic          rstN;
    logic          start;
    logic          busy;
    logic          loadDone;
    logic          loadError;
    logic [AW:0]   wordCount;

    int            assertCount = 0;
    int            failCount   = 0;
    bit            checkOn     = 1'b0;
    wr_t           wlog[$];

    bit            mPrevDone;
    mphase_t       mPhase;
    logic [7:0]    mBytes[$];
    int            mSilent;
    int            mWrites;
    bit            mWe;
    logic [31:0]   mData;

    rx_word_loader_if #(.DATA_WIDTH(8), .WORD_WIDTH(32), .ADDR_WIDTH(AW)) bus ();

    rx_word_loader #(
        .DATA_WIDTH     (8),
        .WORD_WIDTH     (32),
        .ADDR_WIDTH     (AW),
        .HALT_WORD      (32'hFFFF_FFFF),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clock      (clock),
        .i_reset      (rstN),
        .bus          (bus),
        .i_start      (start),
        .o_busy       (busy),
        .o_load_done  (loadDone),
        .o_load_error (loadError),
        .o_word_count (wordCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic expectEq(input string name, input logic [63:0] act, input logic [63:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic checkOutput();
        expectEq("mem_we",     64'(bus.mem_we),   64'(mWe));
        expectEq("mem_addr",   64'(bus.mem_addr), 64'(mWrites % CAP));
        expectEq("mem_data",   64'(bus.mem_data), 64'(mData));
        expectEq("busy",       64'(busy),         64'(mPhase == M_ACTIVE));
        expectEq("load_done",  64'(loadDone),     64'(mPhase == M_DONE));
        expectEq("load_error", 64'(loadError),    64'(mPhase == M_ERROR));
        expectEq("word_count", 64'(wordCount),    64'(mWrites));
    endtask

    task automatic checkWrite(input string name, input int idx, input int addr, input logic [31:0] data);
        if (idx < wlog.size()) begin
            expectEq({name, " addr"}, 64'(wlog[idx].addr), 64'(addr));
            expectEq({name, " data"}, 64'(wlog[idx].data), 64'(data));
        end else begin
            expectEq({name, " present"}, 64'(wlog.size()), 64'(idx + 1));
        end
    endtask

    // Reference model: one update per rising edge from the inputs alone
    always @(posedge clock) begin : model
        bit          byteV;
        bit          weWas;
        logic [31:0] word;
        if (!rstN) begin
            mPrevDone = 1'b0;
            mPhase    = M_IDLE;
            mBytes.delete();
            mSilent   = 0;
            mWrites   = 0;
            mWe       = 1'b0;
            mData     = '0;
        end else begin
            byteV     = bus.rx_done && !mPrevDone;
            mPrevDone = bus.rx_done;
            weWas     = mWe;
            mWe       = 1'b0;
            if (weWas) mWrites++;
            if (mPhase != M_ACTIVE) begin
                if (start) begin
                    mPhase  = M_ACTIVE;
                    mBytes.delete();
                    mSilent = 0;
                    mWrites = 0;
                end
            end else if (byteV) begin
                mBytes.push_back(bus.rx_data);
                mSilent = 0;
                if (mBytes.size() == 4) begin
                    word = {mBytes[0], mBytes[1], mBytes[2], mBytes[3]};
                    mBytes.delete();
                    if (word == 32'hFFFF_FFFF) mPhase = M_DONE;
                    else if (mWrites == CAP)   mPhase = M_ERROR;
                    else begin
                        mWe   = 1'b1;
                        mData = word;
                    end
                end
            end else if (mBytes.size() != 0) begin
                mSilent++;
                if (mSilent == TO) mPhase = M_ERROR;
            end
        end
    end

    // Per-cycle comparison and write logging, away from the active edge
    always @(negedge clock) begin
        if (checkOn) begin
            checkOutput();
            if (bus.mem_we === 1'b1) wlog.push_back('{int'(bus.mem_addr), bus.mem_data});
        end
    end

    task automatic applyStimulus(input logic [7:0] data, input int hold, input int gap);
        bus.rx_done = 1'b1;
        bus.rx_data = data;
        repeat (hold) @(negedge clock);
        bus.rx_done = 1'b0;
        bus.rx_data = 8'($urandom);
        repeat (gap) @(negedge clock);
    endtask

    task automatic sendWord(input logic [31:0] w, input int hold, input int gap);
        for (int i = 3; i >= 0; i--) applyStimulus(w[i*8 +: 8], hold, gap);
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic doReset(input int n);
        rstN = 1'b0;
        repeat (n) @(negedge clock);
        rstN = 1'b1;
    endtask

    initial begin
        int base;
        rstN        = 1'b0;
        start       = 1'b0;
        bus.rx_done = 1'b0;
        bus.rx_data = 8'h00;
        repeat (3) @(negedge clock);
        expectEq("reset mem_we", 64'(bus.mem_we), 64'd0);
        expectEq("reset addr",   64'(bus.mem_addr), 64'd0);
        expectEq("reset busy",   64'(busy), 64'd0);
        expectEq("reset count",  64'(wordCount), 64'd0);
        checkOn = 1'b1;
        rstN    = 1'b1;
        @(negedge clock);

        $display("[TB] basic two-word load");
        base = wlog.size();
        pulseStart();
        sendWord(32'h0102_0304, 1, 2);
        sendWord(32'hAABB_CCDD, 2, 1);
        sendWord(32'hFFFF_FFFF, 1, 1);
        repeat (4) @(negedge clock);
        checkWrite("basic w0", base, 0, 32'h0102_0304);
        checkWrite("basic w1", base + 1, 1, 32'hAABB_CCDD);
        expectEq("basic writes", 64'(wlog.size() - base), 64'd2);
        expectEq("basic done",   64'(loadDone), 64'd1);
        expectEq("basic count",  64'(wordCount), 64'd2);
        expectEq("basic addr",   64'(bus.mem_addr), 64'd2);
        expectEq("model count",  64'(mWrites), 64'd2);

        $display("[TB] long-held bytes");
        base = wlog.size();
        pulseStart();
        sendWord(32'h1234_5678, 16, 3);
        repeat (4) @(negedge clock);
        expectEq("held writes", 64'(wlog.size() - base), 64'd1);
        checkWrite("held w0", base, 0, 32'h1234_5678);
        sendWord(32'hFFFF_FFFF, 1, 1);

        $display("[TB] timeout after partial word");
        base = wlog.size();
        pulseStart();
        applyStimulus(8'h11, 1, 1);
        applyStimulus(8'h22, 1, TO + 10);
        expectEq("timeout error",  64'(loadError), 64'd1);
        expectEq("timeout writes", 64'(wlog.size() - base), 64'd0);
        pulseStart();
        expectEq("restart clears error", 64'(loadError), 64'd0);
        sendWord(32'h0000_0000, 1, 1);
        repeat (3) @(negedge clock);
        checkWrite("after timeout w0", base, 0, 32'h0000_0000);
        sendWord(32'hFFFF_FFFF, 1, 1);

        $display("[TB] memory full");
        base = wlog.size();
        pulseStart();
        for (int i = 0; i < 5; i++) sendWord(32'h1000_0001 + 32'(i), 1, 1);
        repeat (3) @(negedge clock);
        for (int i = 0; i < 4; i++) checkWrite("full w", base + i, i, 32'h1000_0001 + 32'(i));
        expectEq("full writes", 64'(wlog.size() - base), 64'd4);
        expectEq("full error",  64'(loadError), 64'd1);
        expectEq("full count",  64'(wordCount), 64'd4);

        $display("[TB] reset mid-word");
        base = wlog.size();
        pulseStart();
        applyStimulus(8'hDE, 1, 1);
        applyStimulus(8'hAD, 1, 1);
        doReset(2);
        expectEq("midreset busy",  64'(busy), 64'd0);
        expectEq("midreset error", 64'(loadError), 64'd0);
        pulseStart();
        expectEq("midreset start busy", 64'(busy), 64'd1);
        sendWord(32'hCAFE_F00D, 1, 1);
        repeat (3) @(negedge clock);
        checkWrite("midreset w0", base, 0, 32'hCAFE_F00D);
        sendWord(32'hFFFF_FFFF, 1, 1);

        $display("[TB] start ignored while busy");
        base = wlog.size();
        pulseStart();
        sendWord(32'h5566_7788, 1, 1);
        applyStimulus(8'h9A, 1, 1);
        pulseStart();
        applyStimulus(8'hBC, 1, 1);
        applyStimulus(8'hDE, 1, 1);
        applyStimulus(8'hF0, 1, 1);
        repeat (3) @(negedge clock);
        checkWrite("busy start w0", base, 0, 32'h5566_7788);
        checkWrite("busy start w1", base + 1, 1, 32'h9ABC_DEF0);
        expectEq("busy start count", 64'(wordCount), 64'd2);

        $display("[TB] randomized stream");
        for (int n = 0; n < 400; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                doReset(int'($urandom_range(1, 2)));
            end else if (r < 15) begin
                pulseStart();
            end else if (r < 22) begin
                for (int k = 0; k < 4; k++) applyStimulus(8'hFF, int'($urandom_range(1, 4)), int'($urandom_range(1, 3)));
            end else if (r < 27) begin
                applyStimulus(8'($urandom), 1, int'($urandom_range(TO - 3, TO + 2)));
            end else begin
                applyStimulus(8'($urandom), int'($urandom_range(1, 20)), int'($urandom_range(1, 6)));
            end
        end
        repeat (5) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/rx_word_loader.md
Name: rx_word_loader

Overview:
- Sits directly downstream of the UART receiver (rx) in the MIPS IV debug/boot path.
- Consumes rx byte completions (o_rx_done / o_data_out) and packs every 4 bytes, MSB-first, into a 32-bit instruction word.
- Writes each word into instruction memory at auto-incrementing addresses until a halt word arrives, a timeout expires, or memory overflows.
- Reports load completion or error to the debug unit.

Parameters:
- DATA_WIDTH, 8, byte width delivered by rx.
- WORD_WIDTH, 32, instruction word width; must be a multiple of DATA_WIDTH.
- ADDR_WIDTH, 10, word-address width of instruction memory.
- HALT_WORD, 32'hFFFF_FFFF, terminator word; it is never written to memory.
- TIMEOUT_CYCLES, 1_000_000, maximum i_clock cycles allowed between bytes of a partial word.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  synchronous, active-low reset.
- i_rx_done  in  1  rx byte-complete flag. It is a level that stays high for many cycles, not a one-cycle pulse.
- i_rx_data  in  DATA_WIDTH  received byte; valid whenever i_rx_done is high.
- i_start  in  1  arms a new load session at address 0.
- o_mem_we  out  1  one-cycle instruction-memory write strobe.
- o_mem_addr  out  ADDR_WIDTH  word write address.
- o_mem_data  out  WORD_WIDTH  word to write.
- o_busy  out  1  high in RECV or WRITE.
- o_load_done  out  1  sticky; high in DONE.
- o_load_error  out  1  sticky; high in ERROR.
- o_word_count  out  ADDR_WIDTH+1  number of words written this session.

Behaviour:
- Reset, sampled on i_clock rising edge while i_reset==0:
  - state=IDLE; all outputs 0; byte index 0; shift register 0; timeout counter 0; rx_done_q=0.
  - Reset overrides everything, including mid-word or during WRITE; the partial word is discarded.
- Byte strobe: byte_v = i_rx_done & ~rx_done_q, with rx_done_q registered every cycle in all states.
  - A byte held high for N cycles counts exactly once.
  - A level already high on entry to RECV counts once only if rx_done_q==0.
- Packing:
  - On byte_v, shift_reg <= {shift_reg[WORD_WIDTH-DATA_WIDTH-1:0], i_rx_data} and byte_idx increments.
  - The first byte ends in bits [31:24].
  - byte_idx wraps 3->0 when a word completes.
- States are one-hot: IDLE, RECV, WRITE, DONE, ERROR.
- IDLE:
  - Bytes are ignored.
  - i_start=1 -> RECV; addr=0, word_count=0, byte_idx=0, timeout=0.
- RECV:
  - On byte_v with byte_idx==3, the completed word is evaluated:
    - word==HALT_WORD -> DONE, no write.
    - word_count==2^ADDR_WIDTH (memory full) -> ERROR.
    - otherwise -> WRITE.
  - The timeout counter runs only while byte_idx!=0, and clears on every byte_v.
  - Timeout reaching TIMEOUT_CYCLES-1 -> ERROR; the partial word is discarded.
  - i_start is ignored while busy.
- WRITE (exactly 1 cycle):
  - o_mem_we=1, o_mem_addr=addr, o_mem_data=completed word.
  - Next cycle: addr+1 (wraps at 2^ADDR_WIDTH, but the full check precedes it), word_count+1, -> RECV.
  - A byte_v coincident with the WRITE cycle is captured as byte 0 of the next word and is not lost.
- DONE:
  - o_load_done=1.
  - o_mem_addr holds the last written address+1; word_count holds.
  - i_start -> RECV with the session restarted and flags cleared.
- ERROR:
  - o_load_error=1; same restart rule as DONE.
  - Memory contents already written are not rolled back.
- o_mem_addr and o_mem_data are registered; o_mem_we is high only in WRITE.

Decomposition:
- Shared package (debug_pkg):
  - state encodings (5-bit one-hot);
  - HALT_WORD;
  - DATA_WIDTH/WORD_WIDTH defaults;
  - BYTES_PER_WORD = WORD_WIDTH/DATA_WIDTH.
- One sub-module, byte_packer: edge detect, shift register, byte_idx, word_ready pulse.
  - rx_word_loader keeps the FSM, address/count, timeout and memory interface.

Test Plan:
- Start, then bytes 01 02 03 04 AA BB CC DD FF FF FF FF -> writes (0,0x01020304), (1,0xAABBCCDD); o_load_done=1; word_count=2; no write of the halt word.
- i_rx_done held high 16 cycles per byte with data 12 34 56 78 -> exactly one write of 0x12345678.
- TIMEOUT_CYCLES=100: bytes 11 22, then silence for 100 cycles -> o_load_error=1, no write. Then start plus four bytes of 0x00 -> write (0,0x00000000).
- ADDR_WIDTH=2: five non-halt words -> four writes at addr 0..3, then o_load_error=1 on the fifth word, word_count=4.
- i_reset=0 after 2 bytes of a word, then release and start -> state IDLE→RECV; the next 4 bytes form a clean word at addr 0.
- i_start pulsed during RECV -> no effect: address continues and no counters clear.
